// File: rtl/mdu_pkg.sv
// mdu_pkg: operation codes, FSM encoding and op classification shared by the MDU files. Rev 1.0
// Build option: MDU_MACC_EN adds the multiply-accumulate operations to is_long_op.
`default_nettype none

package mdu_pkg;

    typedef enum logic [3:0] {
        OP_NONE  = 4'd0,
        OP_MULT  = 4'd1,
        OP_MULTU = 4'd2,
        OP_DIV   = 4'd3,
        OP_DIVU  = 4'd4,
        OP_MFHI  = 4'd5,
        OP_MFLO  = 4'd6,
        OP_MTHI  = 4'd7,
        OP_MTLO  = 4'd8,
        OP_MADD  = 4'd9,
        OP_MADDU = 4'd10,
        OP_MSUB  = 4'd11,
        OP_MSUBU = 4'd12
    } mdu_op_e;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_e;

    function automatic logic is_long_op(input logic [3:0] op);
        case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: is_long_op = 1'b1;
`ifdef MDU_MACC_EN
            OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: is_long_op = 1'b1;
`endif
            default: is_long_op = 1'b0;
        endcase
    endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_arith.sv
// mdu_arith: combinational multiply/divide/accumulate result for the MDU, plus divide-by-zero flag. Rev 1.0
// Build option: MDU_MACC_EN enables madd/maddu/msub/msubu; otherwise those codes return acc unchanged.
`default_nettype none

module mdu_arith #(
    parameter int WIDTH = 32
) (
    input  logic [3:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [2*WIDTH-1:0] acc,
    output logic [2*WIDTH-1:0] res,
    output logic               div0
);
    import mdu_pkg::*;

    localparam int W2 = 2 * WIDTH;

    logic [W2-1:0]    a_sx, b_sx, a_zx, b_zx, prod_s, prod_u;
    logic [WIDTH-1:0] b_safe, q_s, r_s, q_u, r_u;
    logic             ovf;

    assign a_sx = {{WIDTH{a[WIDTH-1]}}, a};
    assign b_sx = {{WIDTH{b[WIDTH-1]}}, b};
    assign a_zx = {{WIDTH{1'b0}}, a};
    assign b_zx = {{WIDTH{1'b0}}, b};

    // The low 2W bits of a product of sign-extended operands equal the signed product.
    assign prod_s = a_sx * b_sx;
    assign prod_u = a_zx * b_zx;

    assign div0   = (b == '0);
    assign b_safe = div0 ? WIDTH'(1) : b;
    assign ovf    = (a == {1'b1, {(WIDTH-1){1'b0}}}) && (b == '1);

    assign q_s = ovf ? a  : WIDTH'($signed(a) / $signed(b_safe));
    assign r_s = ovf ? '0 : WIDTH'($signed(a) % $signed(b_safe));
    assign q_u = a / b_safe;
    assign r_u = a % b_safe;

    always_comb begin
        res = acc;
        case (op)
            OP_MULT:  res = prod_s;
            OP_MULTU: res = prod_u;
            OP_DIV:   res = div0 ? acc : {r_s, q_s};
            OP_DIVU:  res = div0 ? acc : {r_u, q_u};
`ifdef MDU_MACC_EN
            OP_MADD:  res = acc + prod_s;
            OP_MADDU: res = acc + prod_u;
            OP_MSUB:  res = acc - prod_s;
            OP_MSUBU: res = acc - prod_u;
`endif
            default:  res = acc;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mdu_seq.sv
// mdu_seq: multi-cycle multiply/divide unit with HI/LO, busy, cancel and combinational mfhi/mflo read. Rev 1.0
// Build option: MDU_MACC_EN adds multiply-accumulate ops (latency MULT_CYCLES).
`default_nettype none

module mdu_seq #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       mdu_op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cancel,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] rd
);
    import mdu_pkg::*;

    localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    mdu_state_e       state, state_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [WIDTH-1:0] hi_nx, lo_nx, res_hi, res_lo, res_hi_nx, res_lo_nx;
    logic             wr_en, wr_en_nx;
    logic [2*WIDTH-1:0] arith_res;
    logic             div0;
    logic             is_div;

    mdu_arith #(.WIDTH(WIDTH)) u_arith (
        .op   (mdu_op),
        .a    (a),
        .b    (b),
        .acc  ({hi, lo}),
        .res  (arith_res),
        .div0 (div0)
    );

    assign is_div = (mdu_op == OP_DIV) || (mdu_op == OP_DIVU);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            res_hi <= '0;
            res_lo <= '0;
            wr_en  <= 1'b0;
        end else begin
            state  <= state_nx;
            cnt    <= cnt_nx;
            hi     <= hi_nx;
            lo     <= lo_nx;
            res_hi <= res_hi_nx;
            res_lo <= res_lo_nx;
            wr_en  <= wr_en_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        cnt_nx    = cnt;
        hi_nx     = hi;
        lo_nx     = lo;
        res_hi_nx = res_hi;
        res_lo_nx = res_lo;
        wr_en_nx  = wr_en;
        case (state)
            ST_IDLE: begin
                if (!cancel) begin
                    if (start) begin
                        if (is_long_op(mdu_op)) begin
                            {res_hi_nx, res_lo_nx} = arith_res;
                            // Divide by zero runs its full latency but must leave HI/LO alone.
                            wr_en_nx = !(is_div && div0);
                            cnt_nx   = is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                            state_nx = ST_RUN;
                        end
                    end else if (mdu_op == OP_MTHI) begin
                        hi_nx = a;
                    end else if (mdu_op == OP_MTLO) begin
                        lo_nx = a;
                    end
                end
            end
            ST_RUN: begin
                if (cancel) begin
                    state_nx = ST_IDLE;
                    cnt_nx   = '0;
                end else if (cnt == CNT_W'(1)) begin
                    if (wr_en) begin
                        hi_nx = res_hi;
                        lo_nx = res_lo;
                    end
                    state_nx = ST_IDLE;
                    cnt_nx   = '0;
                end else begin
                    cnt_nx = cnt - CNT_W'(1);
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    assign busy = (state == ST_RUN);

    always_comb begin
        rd = '0;
        if (mdu_op == OP_MFHI)      rd = hi;
        else if (mdu_op == OP_MFLO) rd = lo;
    end

endmodule

`default_nettype wire

// File: tb/tb_mdu_seq.sv
// tb_mdu_seq: scoreboard bench for mdu_seq; a monitor checks HI/LO and busy length whenever busy falls.
`default_nettype none

module tb_mdu_seq;
    import mdu_pkg::*;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        rst_n, start, cancel, busy;
    logic [3:0]  mdu_op;
    logic [31:0] a, b, hi, lo, rd;

    logic        s_start, s_cancel, s_busy;
    logic [3:0]  s_mdu_op;
    logic [15:0] s_a, s_b, s_hi, s_lo, s_rd;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        int          len;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_hi = '0;
    logic [31:0] model_lo = '0;

    always #5 clk = ~clk;

    mdu_seq #(.WIDTH(32), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .mdu_op(mdu_op), .a(a), .b(b),
        .cancel(cancel), .busy(busy), .hi(hi), .lo(lo), .rd(rd)
    );

    mdu_seq #(.WIDTH(16), .MULT_CYCLES(1), .DIV_CYCLES(2)) dut16 (
        .clk(clk), .rst_n(rst_n), .start(s_start), .mdu_op(s_mdu_op), .a(s_a), .b(s_b),
        .cancel(s_cancel), .busy(s_busy), .hi(s_hi), .lo(s_lo), .rd(s_rd)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Reference behaviour from plain 64-bit arithmetic on the architectural HI/LO pair.
    function automatic logic [63:0] ref_result(input logic [3:0] op, input logic [31:0] x,
                                               input logic [31:0] y, input logic [63:0] acc);
        longint      sx, sy, q, r;
        logic [63:0] ux, uy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        ux = {32'h0, x};
        uy = {32'h0, y};
        case (op)
            OP_MULT:  return sx * sy;
            OP_MULTU: return ux * uy;
            OP_DIV: begin
                if (y == 0) return acc;
                q = sx / sy;
                r = sx % sy;
                return {r[31:0], q[31:0]};
            end
            OP_DIVU: begin
                if (y == 0) return acc;
                return {32'(ux % uy), 32'(ux / uy)};
            end
            OP_MADD:  return acc + 64'(sx * sy);
            OP_MADDU: return acc + ux * uy;
            OP_MSUB:  return acc - 64'(sx * sy);
            OP_MSUBU: return acc - ux * uy;
            default:  return acc;
        endcase
    endfunction

    // Issue one long op; cancel_at>0 raises cancel so it is seen on that busy cycle's closing edge.
    task automatic long_op(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                           input int cancel_at);
        int          n;
        logic [63:0] r;
        n = (op == OP_DIV || op == OP_DIVU) ? DC : MC;
        if (cancel_at > 0) begin
            sb.push_back('{hi: model_hi, lo: model_lo, len: cancel_at});
        end else begin
            r = ref_result(op, x, y, {model_hi, model_lo});
            sb.push_back('{hi: r[63:32], lo: r[31:0], len: n});
            model_hi = r[63:32];
            model_lo = r[31:0];
        end
        mdu_op = op; a = x; b = y; start = 1'b1;
        cyc();
        start = 1'b0; mdu_op = OP_NONE;
        if (cancel_at > 0) begin
            repeat (cancel_at - 1) cyc();
            cancel = 1'b1;
            cyc();
            cancel = 1'b0;
        end else begin
            repeat (n) cyc();
        end
        cyc();
    endtask

    task automatic move_to(input logic [3:0] op, input logic [31:0] x);
        mdu_op = op; a = x;
        cyc();
        mdu_op = OP_NONE;
        if (op == OP_MTHI) model_hi = x;
        else               model_lo = x;
        chk("mt_busy", busy, 0);
        chk("mt_hi", hi, model_hi);
        chk("mt_lo", lo, model_lo);
    endtask

    function automatic logic [31:0] rnd_operand();
        case ($urandom_range(0, 7))
            0:       return 32'h0;
            1:       return 32'h1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return 32'h7FFF_FFFF;
            default: return $urandom();
        endcase
    endfunction

    function automatic logic [3:0] rnd_op();
`ifdef MDU_MACC_EN
        case ($urandom_range(0, 7))
            0: return OP_MULT;  1: return OP_MULTU; 2: return OP_DIV;  3: return OP_DIVU;
            4: return OP_MADD;  5: return OP_MADDU; 6: return OP_MSUB; default: return OP_MSUBU;
        endcase
`else
        case ($urandom_range(0, 3))
            0: return OP_MULT; 1: return OP_MULTU; 2: return OP_DIV; default: return OP_DIVU;
        endcase
`endif
    endfunction

    // Monitor: every falling edge of busy retires the oldest expectation.
    int   busy_len = 0;
    logic prev_busy = 1'b0;
    always @(negedge clk) begin
        exp_t e;
        if (busy === 1'b1) begin
            busy_len++;
        end else if (prev_busy) begin
            if (sb.size() == 0) begin
                chk("unexpected_completion", 64'(busy_len), 64'hFFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("res_hi", hi, e.hi);
                chk("res_lo", lo, e.lo);
                chk("busy_len", 64'(busy_len), 64'(e.len));
            end
            busy_len = 0;
        end
        prev_busy = (busy === 1'b1);
    end

    initial begin
        logic [3:0]  op;
        logic [31:0] x, y;
        int          n, k;

        rst_n = 1'b0; start = 1'b0; cancel = 1'b0; mdu_op = OP_NONE; a = '0; b = '0;
        s_start = 1'b0; s_cancel = 1'b0; s_mdu_op = OP_NONE; s_a = '0; s_b = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", busy, 0);
        chk("reset_hi", hi, 0);
        chk("reset_lo", lo, 0);
        chk("reset_rd", rd, 0);
        rst_n = 1'b1;
        cyc();

        // 16-bit instance with single-cycle multiply.
        s_mdu_op = OP_MULT; s_a = 16'h8000; s_b = 16'h8000; s_start = 1'b1;
        cyc();
        s_start = 1'b0; s_mdu_op = OP_NONE;
        @(negedge clk);
        chk("w16_busy_on", s_busy, 1);
        @(negedge clk);
        chk("w16_busy_off", s_busy, 0);
        chk("w16_hi", s_hi, 16'h4000);
        chk("w16_lo", s_lo, 16'h0000);
        cyc();

        long_op(OP_MULT,  32'hFFFF_FFFE, 32'd3, 0);
        long_op(OP_MULTU, 32'hFFFF_FFFE, 32'd3, 0);
        long_op(OP_DIV,   32'hFFFF_FFF9, 32'd2, 0);
        long_op(OP_DIVU,  32'd7,         32'd0, 0);
        long_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 0);

        move_to(OP_MTHI, 32'h1234_5678);
        mdu_op = OP_MFLO; #1;
        chk("rd_mflo", rd, model_lo);
        mdu_op = OP_MFHI; #1;
        chk("rd_mfhi", rd, 32'h1234_5678);
        mdu_op = OP_MTHI; #1;
        chk("rd_other", rd, 0);
        mdu_op = OP_NONE;

        long_op(OP_MULT, 32'h0001_0000, 32'h0001_0000, 3);

        // cancel in IDLE suppresses start and move-to; start with a non-long op is ignored.
        mdu_op = OP_MULT; a = 32'd9; b = 32'd9; start = 1'b1; cancel = 1'b1;
        cyc();
        start = 1'b0; mdu_op = OP_MTLO; a = 32'hDEAD_BEEF;
        cyc();
        cancel = 1'b0; mdu_op = OP_MTHI; a = 32'hCAFE_F00D; start = 1'b1;
        cyc();
        start = 1'b0; mdu_op = OP_NONE;
        chk("idle_cancel_busy", busy, 0);
        chk("idle_cancel_hi", hi, model_hi);
        chk("idle_cancel_lo", lo, model_lo);

        move_to(OP_MTHI, 32'h0);
        move_to(OP_MTLO, 32'hFFFF_FFFF);
`ifdef MDU_MACC_EN
        long_op(OP_MADDU, 32'd1, 32'd1, 0);
        chk("maddu_hi", model_hi, 32'd1);
`else
        mdu_op = OP_MADDU; a = 32'd1; b = 32'd1; start = 1'b1;
        cyc();
        start = 1'b0; mdu_op = OP_NONE;
        @(negedge clk);
        chk("maddu_off_busy", busy, 0);
        chk("maddu_off_hi", hi, 32'h0);
        chk("maddu_off_lo", lo, 32'hFFFF_FFFF);
        cyc();
`endif

        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 3) == 0)
                move_to(($urandom_range(0, 1) == 0) ? OP_MTHI : OP_MTLO, $urandom());
            op = rnd_op();
            x  = rnd_operand();
            y  = rnd_operand();
            n  = (op == OP_DIV || op == OP_DIVU) ? DC : MC;
            k  = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, n - 1)) : 0;
            long_op(op, x, y, k);
        end

        // Asynchronous reset in the middle of a divide.
        sb.push_back('{hi: 32'h0, lo: 32'h0, len: 4});
        mdu_op = OP_DIV; a = 32'd100; b = 32'd3; start = 1'b1;
        cyc();
        start = 1'b0; mdu_op = OP_NONE;
        repeat (4) cyc();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", busy, 0);
        chk("rst_mid_hi", hi, 0);
        chk("rst_mid_lo", lo, 0);
        model_hi = '0;
        model_lo = '0;
        cyc();
        rst_n = 1'b1;
        cyc();
        long_op(OP_MULTU, 32'd5, 32'd7, 0);

        repeat (3) cyc();
        chk("scoreboard_drained", 64'(sb.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
- Parametrised multi-cycle multiply/divide unit with HI/LO registers. Sits in the E stage beside the ALU.
- Executes the MDU_op/start pair from the decoder.
- Exposes busy so the hazard logic can stall mult/div/mfhi/mflo/mthi/mtlo behind an in-flight operation.
- Successor of the fixed 32-bit unit: width and latencies are generic; adds a cancel input and an optional accumulate mode.

Parameters:
- WIDTH, 32, operand, HI and LO width.
- MULT_CYCLES, 5, cycles busy after a multiply start (>=1).
- DIV_CYCLES, 10, cycles busy after a divide start (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  one-cycle pulse launching mult/multu/div/divu (plus madd/maddu/msub/msubu when the feature is built).
- mdu_op  in  4  operation code from the shared package.
- a  in  WIDTH  rs operand (forwarded).
- b  in  WIDTH  rt operand (forwarded).
- cancel  in  1  abort the in-flight operation (flush).
- busy  out  1  operation in flight.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.
- rd  out  WIDTH  mfhi -> hi, mflo -> lo, otherwise 0. Combinational.

Behaviour:
- Reset: hi=0, lo=0, busy=0, cnt=0, state IDLE. Asynchronous on rst_n low, including mid-operation; any pending result is discarded.
- States:
  - IDLE: on start with a valid long op, latch the result into res_hi/res_lo, load cnt=MULT_CYCLES or DIV_CYCLES, go to RUN.
  - RUN: busy=1 while in RUN; cnt decrements each cycle.
  - At cnt==1: HI/LO take the result at that clock edge, return to IDLE.
  - Net effect: busy is high exactly N cycles starting the cycle after start. HI/LO are visible the cycle busy falls.
- Arithmetic:
  - mult: signed WIDTH x WIDTH -> 2*WIDTH; {hi,lo}=product.
  - multu: same, unsigned.
  - div: lo=quotient truncated toward zero, hi=remainder with the dividend's sign.
  - divu: unsigned quotient and remainder.
- Divide by zero: busy for DIV_CYCLES as normal; hi and lo are unchanged.
- Signed overflow (most negative / -1): lo=most negative value, hi=0.
- mthi/mtlo: in IDLE with start=0, write a to hi/lo at the next edge, single cycle, busy stays 0.
- Ignored inputs:
  - mthi/mtlo or start while busy (hazard logic guarantees they do not occur).
  - start with a non-long op.
  - start and mthi/mtlo in the same cycle: start wins.
- cancel:
  - In RUN: return to IDLE next edge, busy=0, hi/lo keep their pre-start values.
  - In IDLE: suppresses a same-cycle start or mthi/mtlo.
- rd reads the current hi/lo. It returns pre-operation values only if sampled while busy, which the stall logic prevents.

Optional Feature:
- MDU_MACC_EN defined: adds madd/maddu/msub/msubu.
  - Operation: {hi,lo} <= {hi,lo} +/- (a*b), signed or unsigned per op, modulo 2^(2*WIDTH).
  - Latency MULT_CYCLES. The accumulator snapshot is taken at start.
- MDU_MACC_EN undefined: these codes are treated as invalid and ignored; no accumulate hardware.

Decomposition:
- Shared package mdu_pkg holds:
  - mdu_op codes: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MFHI=5, MFLO=6, MTHI=7, MTLO=8, MADD=9, MADDU=10, MSUB=11, MSUBU=12.
  - State encoding IDLE/RUN.
  - Helper constant is_long_op(op).
- Sub-module mdu_arith: purely combinational. Computes {res_hi,res_lo} and a div0 flag from op/a/b/{hi,lo}. Keeps the FSM and counter in mdu_seq.

Test Plan:
- Multiply: mult a=0xFFFFFFFE (-2), b=3, start -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA; multu on the same operands -> hi=0x00000002, lo=0xFFFFFFFA.
- Divide: div a=-7, b=2 -> after 10 busy cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu a=7, b=0 -> busy 10 cycles, hi/lo unchanged.
- Move to/from HI/LO: mthi a=0x12345678 then mflo/mfhi -> hi=0x12345678 the next cycle, busy never set, rd follows op.
- Cancel: mult 0x10000 x 0x10000, assert cancel at cycle 3 of busy -> busy drops next cycle, hi/lo keep their prior values; rst_n low mid-divide -> hi=lo=0, busy=0 immediately.
- Overflow and parameters: div 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0; with WIDTH=16, MULT_CYCLES=1, mult 0x8000 x 0x8000 -> hi=0x4000, lo=0, busy exactly 1 cycle.
- Accumulate (MDU_MACC_EN): hi=0, lo=0xFFFFFFFF, maddu 1 x 1 -> hi=1, lo=0; without the macro the same op leaves hi/lo unchanged and busy=0.
